// File: rtl/accum_sampler.sv
// rtl/accum_sampler.sv - periodic/on-request snapshot of a sticky-bit accumulator with merge-on-overrun.
// Optional macro ACC_SAMPLER_SEQ_EN adds an 8-bit sample sequence number output (snap_seq).
module accum_sampler #(
  parameter int WIDTH      = 8,
  parameter int INTERVAL   = 125000,
  parameter int OFFER_ZERO = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] acc_i,
  output logic             acc_clear,
  input  logic             sample_req,
  output logic [WIDTH-1:0] snap_data,
  output logic             snap_valid,
  input  logic             snap_ready,
`ifdef ACC_SAMPLER_SEQ_EN
  output logic [7:0]       snap_seq,
`endif
  output logic             snap_overrun
);

  localparam int CW = $clog2(INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  typedef enum logic {ST_COUNT, ST_SAMPLE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
`ifdef ACC_SAMPLER_SEQ_EN
  logic [7:0]       seq_cnt_q, seq_cnt_d;
  logic [7:0]       seq_q, seq_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef ACC_SAMPLER_SEQ_EN
    seq_cnt_d = seq_cnt_q;
    seq_d     = seq_q;
`endif

    if (state_q == ST_COUNT) begin
      if ((count_q == LAST) || sample_req) begin
        state_d = ST_SAMPLE;
        count_d = '0;
      end
      if (valid_q && snap_ready) begin
        valid_d = 1'b0;
        ovr_d   = 1'b0;
      end
    end else begin
      state_d = ST_COUNT;
`ifdef ACC_SAMPLER_SEQ_EN
      seq_cnt_d = seq_cnt_q + 8'd1;
      seq_d     = seq_cnt_q + 8'd1;
`endif
      // An unaccepted snapshot absorbs the new bits instead of being lost.
      if (!valid_q || snap_ready) begin
        data_d  = acc_i;
        ovr_d   = 1'b0;
        valid_d = (acc_i != '0) || (OFFER_ZERO != 0);
      end else begin
        data_d  = data_q | acc_i;
        ovr_d   = 1'b1;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_COUNT;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef ACC_SAMPLER_SEQ_EN
      seq_cnt_q <= '0;
      seq_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef ACC_SAMPLER_SEQ_EN
      seq_cnt_q <= seq_cnt_d;
      seq_q     <= seq_d;
`endif
    end
  end

  // Reset also holds the accumulator clear so it starts empty.
  assign acc_clear    = reset | (state_q == ST_SAMPLE);
  assign snap_data    = data_q;
  assign snap_valid   = valid_q;
  assign snap_overrun = ovr_q;
`ifdef ACC_SAMPLER_SEQ_EN
  assign snap_seq     = seq_q;
`endif

endmodule
